// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared definitions for the ALU sequencer: opcode values,
//                ALU mode encodings, controller state type and error codes.
//  Optional    : ALU_SEQ_XCH_EN makes OP_XCH a legal opcode (see top).
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

   // Instruction opcodes (OPR field, instr[7:4])
   localparam logic [3:0] OP_LDI   = 4'b0001;
   localparam logic [3:0] OP_MODE1 = 4'b0010;
   localparam logic [3:0] OP_ADDR  = OP_MODE1;   // first ALU opcode
   localparam logic [3:0] OP_MODE2 = 4'b0011;
   localparam logic [3:0] OP_MODE3 = 4'b0100;
   localparam logic [3:0] OP_MODE4 = 4'b0101;
   localparam logic [3:0] OP_XCH   = 4'b0110;
   localparam logic [3:0] OP_STR   = 4'b0111;

   // ALU mode encodings driven on alu_mode
   localparam logic [2:0] MODE_NONE = 3'd0;
   localparam logic [2:0] MODE_1    = 3'd1;
   localparam logic [2:0] MODE_2    = 3'd2;
   localparam logic [2:0] MODE_3    = 3'd3;
   localparam logic [2:0] MODE_4    = 3'd4;

   // Abort reasons reported on err_code
   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_INDEX   = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_ISSUE  = 2'd2,
      ST_WAIT   = 2'd3
   } seq_state_t;

   function automatic logic is_alu_op(input logic [3:0] opr);
      return (opr == OP_MODE1) || (opr == OP_MODE2) ||
             (opr == OP_MODE3) || (opr == OP_MODE4);
   endfunction

   function automatic logic [2:0] opr_to_mode(input logic [3:0] opr);
      logic [2:0] mode;
      case (opr)
         OP_MODE1: mode = MODE_1;
         OP_MODE2: mode = MODE_2;
         OP_MODE3: mode = MODE_3;
         OP_MODE4: mode = MODE_4;
         default:  mode = MODE_NONE;
      endcase
      return mode;
   endfunction

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_seq_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_regfile
//  Description : NUM_REGS x 4-bit register file with one asynchronous read
//                port and one synchronous write port. Synchronous reset
//                clears every entry. Out-of-range reads return 0 and
//                out-of-range writes are dropped.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                i_we              - write enable
//                i_waddr, i_wdata  - write index (4-bit) and data
//                i_raddr, o_rdata  - read index (4-bit) and data
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_regfile
   import alu_seq_pkg::*;
#(
   parameter int NUM_REGS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_we,
   input  logic [3:0] i_waddr,
   input  logic [3:0] i_wdata,
   input  logic [3:0] i_raddr,
   output logic [3:0] o_rdata
);

   localparam int         c_AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [4:0] c_DEPTH = 5'(NUM_REGS);

   logic [3:0] r_mem [NUM_REGS];
   logic       w_rd_ok;
   logic       w_wr_ok;

   assign w_rd_ok = ({1'b0, i_raddr} < c_DEPTH);
   assign w_wr_ok = ({1'b0, i_waddr} < c_DEPTH);

   assign o_rdata = w_rd_ok ? r_mem[i_raddr[c_AW-1:0]] : 4'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_mem[i] <= 4'd0;
         end
      end else if (i_we && w_wr_ok) begin
         r_mem[i_waddr[c_AW-1:0]] <= i_wdata;
      end
   end

endmodule : alu_seq_regfile
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Single-issue instruction sequencer. Accepts one 8-bit
//                instruction at a time (OPR=[7:4], OPA=[3:0]), executes LDI
//                and STR locally and hands ALU modes 1-4 to an external
//                multi-cycle ALU through a start/done handshake. Owns the
//                accumulator, status and the register file.
//  Ports       : clk, rst                 - clock, sync active-high reset
//                instr, instr_valid/ready - instruction handshake
//                alu_start/mode/index/acc/opnd - ALU request (held ISSUE..WAIT)
//                alu_done/result/flags    - ALU response
//                acc_out, status_out      - architectural state
//                busy, done, err, err_code - progress and abort reporting
//  Optional    : ALU_SEQ_XCH_EN - enables OPR=0110 (XCH: swap acc and
//                reg[OPA]); otherwise 0110 is an illegal opcode.
//  Timing      : done/err are registered pulses, visible the cycle after the
//                deciding state (LDI: accept cycle + 2). The ALU may answer
//                in any of the TIMEOUT_CYCLES WAIT cycles following the
//                alu_start cycle; without an answer err rises on the
//                TIMEOUT_CYCLES-th clock edge after alu_start is sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 15,
   parameter int NUM_REGS       = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] instr,
   input  logic       instr_valid,
   output logic       instr_ready,
   output logic       alu_start,
   output logic [2:0] alu_mode,
   output logic [3:0] alu_index,
   output logic [3:0] alu_acc,
   output logic [3:0] alu_opnd,
   input  logic       alu_done,
   input  logic [3:0] alu_result,
   input  logic [3:0] alu_flags,
   output logic [3:0] acc_out,
   output logic [3:0] status_out,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code
);

   localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT_CYCLES);
   localparam logic [4:0] c_DEPTH   = 5'(NUM_REGS);

   seq_state_t r_state;
   seq_state_t w_next;

   logic [7:0] r_instr;
   logic [3:0] r_acc;
   logic [3:0] r_status;
   logic [2:0] r_mode;
   logic [3:0] r_index;
   logic [3:0] r_alu_acc;
   logic [3:0] r_opnd;
   logic [7:0] r_cnt;
   logic       r_done;
   logic       r_err;
   logic [1:0] r_err_code;

   logic [3:0] w_opr;
   logic [3:0] w_opa;
   logic [3:0] w_rdata;
   logic       w_idx_ok;
   logic       w_is_ldi;
   logic       w_is_str;
   logic       w_is_alu;
   logic       w_is_xch;
   logic       w_needs_idx;

   logic       w_we;
   logic       w_ld_imm;
   logic       w_swap;
   logic       w_latch_op;
   logic       w_ld_res;
   logic       w_fin_done;
   logic       w_fin_err;
   logic [1:0] w_code;

   // ------------------------------------------------------------------
   // Decode of the latched instruction
   // ------------------------------------------------------------------
   assign w_opr    = r_instr[7:4];
   assign w_opa    = r_instr[3:0];
   assign w_idx_ok = ({1'b0, w_opa} < c_DEPTH);
   assign w_is_ldi = (w_opr == OP_LDI);
   assign w_is_str = (w_opr == OP_STR);
   assign w_is_alu = is_alu_op(w_opr);
`ifdef ALU_SEQ_XCH_EN
   assign w_is_xch = (w_opr == OP_XCH);
`else
   assign w_is_xch = 1'b0;
`endif
   assign w_needs_idx = w_is_str | w_is_alu | w_is_xch;

   // Register file: read and write share the OPA index. XCH writes the old
   // acc while acc captures the old register value on the same edge.
   alu_seq_regfile #(
      .NUM_REGS (NUM_REGS)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we),
      .i_waddr (w_opa),
      .i_wdata (r_acc),
      .i_raddr (w_opa),
      .o_rdata (w_rdata)
   );

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM next state and datapath controls
   // ------------------------------------------------------------------
   always_comb begin
      w_next     = r_state;
      w_we       = 1'b0;
      w_ld_imm   = 1'b0;
      w_swap     = 1'b0;
      w_latch_op = 1'b0;
      w_ld_res   = 1'b0;
      w_fin_done = 1'b0;
      w_fin_err  = 1'b0;
      w_code     = r_err_code;
      case (r_state)
         ST_IDLE: begin
            if (instr_valid) begin
               w_next = ST_DECODE;
            end
         end
         ST_DECODE: begin
            w_next = ST_IDLE;
            if (w_is_ldi) begin
               w_ld_imm   = 1'b1;
               w_fin_done = 1'b1;
            end else if (w_needs_idx && !w_idx_ok) begin
               w_fin_err = 1'b1;
               w_code    = ERR_INDEX;
            end else if (w_is_alu) begin
               w_latch_op = 1'b1;
               w_next     = ST_ISSUE;
            end else if (w_is_str) begin
               w_we       = 1'b1;
               w_fin_done = 1'b1;
            end else if (w_is_xch) begin
               w_we       = 1'b1;
               w_swap     = 1'b1;
               w_fin_done = 1'b1;
            end else begin
               w_fin_err = 1'b1;
               w_code    = ERR_ILLEGAL;
            end
         end
         ST_ISSUE: begin
            // alu_done is deliberately not looked at here
            w_next = ST_WAIT;
         end
         ST_WAIT: begin
            // A response on the last allowed cycle still wins over timeout
            if (alu_done) begin
               w_ld_res   = 1'b1;
               w_fin_done = 1'b1;
               w_next     = ST_IDLE;
            end else if (r_cnt == 8'd1) begin
               w_fin_err = 1'b1;
               w_code    = ERR_TIMEOUT;
               w_next    = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Architectural state and ALU request registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_instr    <= 8'd0;
         r_acc      <= 4'd0;
         r_status   <= 4'd0;
         r_mode     <= MODE_NONE;
         r_index    <= 4'd0;
         r_alu_acc  <= 4'd0;
         r_opnd     <= 4'd0;
         r_cnt      <= 8'd0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= ERR_NONE;
      end else begin
         r_done <= w_fin_done;
         r_err  <= w_fin_err;
         if (w_fin_err) begin
            r_err_code <= w_code;
         end

         if ((r_state == ST_IDLE) && instr_valid) begin
            r_instr <= instr;
         end

         if (w_ld_imm) begin
            r_acc    <= w_opa;
            r_status <= 4'd0;
         end else if (w_swap) begin
            r_acc <= w_rdata;
         end else if (w_ld_res) begin
            r_acc    <= alu_result;
            r_status <= alu_flags;
         end

         if (w_latch_op) begin
            r_mode    <= opr_to_mode(w_opr);
            r_index   <= w_opa;
            r_alu_acc <= r_acc;
            r_opnd    <= w_rdata;
         end

         // Counter holds the number of WAIT cycles still available
         if (r_state == ST_ISSUE) begin
            r_cnt <= c_TIMEOUT;
         end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt - 8'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign instr_ready = (r_state == ST_IDLE);
   assign busy        = (r_state != ST_IDLE);
   assign alu_start   = (r_state == ST_ISSUE);
   assign alu_mode    = r_mode;
   assign alu_index   = r_index;
   assign alu_acc     = r_alu_acc;
   assign alu_opnd    = r_opnd;
   assign acc_out     = r_acc;
   assign status_out  = r_status;
   assign done        = r_done;
   assign err         = r_err;
   assign err_code    = r_err_code;

endmodule : alu_sequencer
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Self-checking bench for alu_sequencer. A transaction-level
//                model (acc, status, register array, last error code) gives
//                the expected outcome of each instruction; the bench plays
//                the ALU with a chosen response delay.
//  Optional    : ALU_SEQ_XCH_EN selects the expected XCH behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

   localparam int c_TO   = 6;
   localparam int c_NREG = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] instr;
   logic       instr_valid;
   logic       instr_ready;
   logic       alu_start;
   logic [2:0] alu_mode;
   logic [3:0] alu_index;
   logic [3:0] alu_acc;
   logic [3:0] alu_opnd;
   logic       alu_done;
   logic [3:0] alu_result;
   logic [3:0] alu_flags;
   logic [3:0] acc_out;
   logic [3:0] status_out;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] err_code;

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model state
   logic [3:0] m_acc;
   logic [3:0] m_status;
   logic [3:0] m_regs [c_NREG];
   logic [1:0] m_code;

   alu_sequencer #(
      .TIMEOUT_CYCLES (c_TO),
      .NUM_REGS       (c_NREG)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .alu_start   (alu_start),
      .alu_mode    (alu_mode),
      .alu_index   (alu_index),
      .alu_acc     (alu_acc),
      .alu_opnd    (alu_opnd),
      .alu_done    (alu_done),
      .alu_result  (alu_result),
      .alu_flags   (alu_flags),
      .acc_out     (acc_out),
      .status_out  (status_out),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .err_code    (err_code)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset;
      m_acc    = 4'd0;
      m_status = 4'd0;
      m_code   = 2'b00;
      for (int i = 0; i < c_NREG; i++) m_regs[i] = 4'd0;
   endtask

   // Runs one instruction end to end.
   // dly: 1..c_TO = ALU answers in that WAIT cycle; 0 = never answers;
   //      -1 = spurious pulse in the alu_start cycle and no real answer.
   task automatic do_instr(input logic [7:0] ins, input int dly,
                           input logic [3:0] res, input logic [3:0] fl);
      logic [3:0] opr;
      logic [3:0] opa;
      logic       in_rng;
      logic       exp_done;
      logic       exp_err;
      logic       answered;
      logic [3:0] tmp;
      int         guard;
      int         k;
      opr      = ins[7:4];
      opa      = ins[3:0];
      in_rng   = (int'(opa) < c_NREG);
      exp_done = 1'b0;
      exp_err  = 1'b0;
      answered = 1'b0;

      guard = 0;
      while (!instr_ready && guard < 40) begin
         tick();
         guard++;
      end
      check_eq("ready_before_issue", {31'd0, instr_ready}, 32'd1);

      instr       = ins;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      instr       = 8'($urandom);
      check_eq("busy_decode", {31'd0, busy}, 32'd1);

      if (opr >= 4'd2 && opr <= 4'd5 && in_rng) begin
         tick();
         check_eq("alu_start", {31'd0, alu_start}, 32'd1);
         check_eq("alu_mode", {29'd0, alu_mode}, 32'(opr) - 32'd1);
         check_eq("alu_index", {28'd0, alu_index}, {28'd0, opa});
         check_eq("alu_acc", {28'd0, alu_acc}, {28'd0, m_acc});
         check_eq("alu_opnd", {28'd0, alu_opnd}, {28'd0, m_regs[int'(opa)]});
         if (dly < 0) begin
            alu_done   = 1'b1;
            alu_result = ~m_acc;
            alu_flags  = 4'hF;
         end
         k = 0;
         while (k < c_TO && !answered) begin
            tick();
            alu_done = 1'b0;
            k++;
            check_eq("wait_quiet", {30'd0, done, err}, 32'd0);
            check_eq("start_pulse_once", {31'd0, alu_start}, 32'd0);
            if (k == dly) begin
               alu_done   = 1'b1;
               alu_result = res;
               alu_flags  = fl;
               tick();
               alu_done = 1'b0;
               answered = 1'b1;
            end
         end
         if (!answered) tick();
         if (answered) begin
            m_acc    = res;
            m_status = fl;
            exp_done = 1'b1;
         end else begin
            m_code  = 2'b11;
            exp_err = 1'b1;
         end
      end else begin
         tick();
         case (opr)
            4'd1: begin
               m_acc    = opa;
               m_status = 4'd0;
               exp_done = 1'b1;
            end
            4'd2, 4'd3, 4'd4, 4'd5: begin
               m_code  = 2'b10;
               exp_err = 1'b1;
            end
            4'd7: begin
               if (in_rng) begin
                  m_regs[int'(opa)] = m_acc;
                  exp_done = 1'b1;
               end else begin
                  m_code  = 2'b10;
                  exp_err = 1'b1;
               end
            end
`ifdef ALU_SEQ_XCH_EN
            4'd6: begin
               if (in_rng) begin
                  tmp               = m_acc;
                  m_acc             = m_regs[int'(opa)];
                  m_regs[int'(opa)] = tmp;
                  exp_done          = 1'b1;
               end else begin
                  m_code  = 2'b10;
                  exp_err = 1'b1;
               end
            end
`endif
            default: begin
               m_code  = 2'b01;
               exp_err = 1'b1;
            end
         endcase
      end

      check_eq($sformatf("done_%02h", ins), {31'd0, done}, {31'd0, exp_done});
      check_eq($sformatf("err_%02h", ins), {31'd0, err}, {31'd0, exp_err});
      check_eq($sformatf("err_code_%02h", ins), {30'd0, err_code}, {30'd0, m_code});
      check_eq($sformatf("acc_%02h", ins), {28'd0, acc_out}, {28'd0, m_acc});
      check_eq($sformatf("status_%02h", ins), {28'd0, status_out}, {28'd0, m_status});
      tick();
      check_eq("pulse_width", {30'd0, done, err}, 32'd0);
      check_eq("ready_after", {31'd0, instr_ready}, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int         sel;
      logic [3:0] opr;
      logic [3:0] opa;
      int         dly;

      rst         = 1'b1;
      instr       = 8'd0;
      instr_valid = 1'b0;
      alu_done    = 1'b0;
      alu_result  = 4'd0;
      alu_flags   = 4'd0;
      model_reset();
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check_eq("rst_ready", {31'd0, instr_ready}, 32'd1);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_acc", {28'd0, acc_out}, 32'd0);
      check_eq("rst_status", {28'd0, status_out}, 32'd0);
      check_eq("rst_pulses", {29'd0, alu_start, done, err}, 32'd0);
      check_eq("rst_alu_regs", {17'd0, alu_mode, alu_index, alu_acc, alu_opnd}, 32'd0);
      check_eq("rst_err_code", {30'd0, err_code}, 32'd0);

      // Directed sequence
      do_instr(8'h1A, 0, 4'd0, 4'd0);
      do_instr(8'h15, 0, 4'd0, 4'd0);
      do_instr(8'h73, 0, 4'd0, 4'd0);
      do_instr(8'h11, 0, 4'd0, 4'd0);
      do_instr(8'h23, 3, 4'd6, 4'd2);
      do_instr(8'h29, 0, 4'd0, 4'd0);
      do_instr(8'hF0, 0, 4'd0, 4'd0);
      do_instr(8'h33, 0, 4'd0, 4'd0);      // timeout
      do_instr(8'h43, c_TO, 4'd9, 4'd5);   // answer on the last cycle
      do_instr(8'h53, -1, 4'd0, 4'd0);     // pulse in ISSUE ignored
      do_instr(8'h19, 0, 4'd0, 4'd0);
      do_instr(8'h72, 0, 4'd0, 4'd0);
      do_instr(8'h14, 0, 4'd0, 4'd0);
      do_instr(8'h62, 0, 4'd0, 4'd0);      // XCH or illegal
      do_instr(8'h22, 1, 4'd3, 4'd1);      // exposes R2 on alu_opnd
      do_instr(8'h7F, 0, 4'd0, 4'd0);

      // Reset while waiting on the ALU, then a stray alu_done in IDLE
      instr       = 8'h21;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      check_eq("wrst_ready", {31'd0, instr_ready}, 32'd1);
      check_eq("wrst_busy", {31'd0, busy}, 32'd0);
      check_eq("wrst_pulses", {30'd0, done, err}, 32'd0);
      check_eq("wrst_acc", {28'd0, acc_out}, 32'd0);
      alu_done   = 1'b1;
      alu_result = 4'hE;
      alu_flags  = 4'hE;
      tick();
      alu_done = 1'b0;
      check_eq("stray_pulses", {30'd0, done, err}, 32'd0);
      check_eq("stray_acc", {28'd0, acc_out}, 32'd0);
      check_eq("stray_status", {28'd0, status_out}, 32'd0);
      check_eq("stray_busy", {31'd0, busy}, 32'd0);

      // Randomized traffic
      for (int n = 0; n < 200; n++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1:    opr = 4'd1;
            2, 9:    opr = 4'd7;
            3:       opr = 4'd2;
            4:       opr = 4'd3;
            5:       opr = 4'd4;
            6:       opr = 4'd5;
            7:       opr = 4'd6;
            default: begin
               sel = $urandom_range(0, 8);
               opr = (sel == 0) ? 4'd0 : 4'(7 + sel);
            end
         endcase
         opa = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15))
                                           : 4'($urandom_range(0, 7));
         sel = $urandom_range(0, 9);
         if (sel == 0)      dly = 0;
         else if (sel == 1) dly = -1;
         else               dly = $urandom_range(1, c_TO);
         do_instr({opr, opa}, dly, 4'($urandom), 4'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule : tb_alu_sequencer
`default_nettype wire
